// File: rtl/contador_updown_param.sv
// Saturating up/down occupancy counter with load, level flags,
// sticky overflow/underflow errors and a peak-occupancy register.
module contador_updown_param #(
    parameter int WIDTH     = 3,
    parameter int MAX       = 7,
    parameter int AF_THRESH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Z0,
    input  logic             Z1,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] c,
    output logic             lleno,
    output logic             vacio,
    output logic             casi_lleno,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic [WIDTH-1:0] pico
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] AFV  = WIDTH'(AF_THRESH);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC,
        OP_SAT_HI,
        OP_SAT_LO
    } op_t;

    op_t              op;
    logic [WIDTH-1:0] c_next;
    logic [WIDTH-1:0] pico_next;
    logic [WIDTH-1:0] load_sat;
    logic             ovf_set;
    logic             unf_set;
    logic             ovf_next;
    logic             unf_next;

    // Level flags decode straight from the registered count.
    always_comb begin
        lleno      = (c == MAXV);
        vacio      = (c == '0);
        casi_lleno = (c >= AFV);
    end

    // Classify this cycle's request; load outranks Z0/Z1, 11 nets to hold.
    always_comb begin
        op = OP_HOLD;
        unique case (1'b1)
            load:
                op = OP_LOAD;
            (!load && Z0 && !Z1):
                op = lleno ? OP_SAT_HI : OP_INC;
            (!load && Z1 && !Z0):
                op = vacio ? OP_SAT_LO : OP_DEC;
            default:
                op = OP_HOLD;
        endcase
    end

    // Next count, clamping loaded values to the ceiling.
    always_comb begin
        load_sat = (load_val > MAXV) ? MAXV : load_val;
        c_next   = c;
        case (op)
            OP_LOAD: c_next = load_sat;
            OP_INC:  c_next = c + 1'b1;
            OP_DEC:  c_next = c - 1'b1;
            default: c_next = c;
        endcase
    end

    // Sticky errors: a new error beats a simultaneous clear.
    always_comb begin
        ovf_set  = (op == OP_SAT_HI);
        unf_set  = (op == OP_SAT_LO);
        ovf_next = ovf_set | (overflow_err & ~clr_err);
        unf_next = unf_set | (underflow_err & ~clr_err);
    end

    // Peak follows the new count so it moves in step with c.
    always_comb begin
        pico_next = (c_next > pico) ? c_next : pico;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c             <= '0;
            pico          <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            c             <= c_next;
            pico          <= pico_next;
            overflow_err  <= ovf_next;
            underflow_err <= unf_next;
        end
    end

endmodule

// File: tb/tb_contador_updown_param.sv
// Randomised self-checking bench for contador_updown_param,
// exercising the default 3-bit build and a 4-bit, MAX=10 build.
module tb_contador_updown_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       Z0, Z1, load, clr_err;
    logic [2:0] lv;
    logic [3:0] lv4;

    logic [2:0] c0, p0;
    logic       ll0, va0, ca0, ov0, un0;
    logic [3:0] c1, p1;
    logic       ll1, va1, ca1, ov1, un1;

    always #5 clk = ~clk;

    contador_updown_param dut (
        .clk(clk), .rst(rst), .Z0(Z0), .Z1(Z1),
        .load(load), .load_val(lv), .clr_err(clr_err),
        .c(c0), .lleno(ll0), .vacio(va0), .casi_lleno(ca0),
        .overflow_err(ov0), .underflow_err(un0), .pico(p0)
    );

    contador_updown_param #(
        .WIDTH(4), .MAX(10), .AF_THRESH(8)
    ) dut4 (
        .clk(clk), .rst(rst), .Z0(Z0), .Z1(Z1),
        .load(load), .load_val(lv4), .clr_err(clr_err),
        .c(c1), .lleno(ll1), .vacio(va1), .casi_lleno(ca1),
        .overflow_err(ov1), .underflow_err(un1), .pico(p1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int mx[2] = '{7, 10};
    int af[2] = '{6, 8};
    int mc[2], mp[2], mo[2], mu[2];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; mp[i] = 0; mo[i] = 0; mu[i] = 0;
        end
    endtask

    task automatic model_step(input bit z0, input bit z1,
                              input bit ld, input int l0,
                              input int l1, input bit clr);
        for (int i = 0; i < 2; i++) begin
            int nc;
            int lvx;
            bit so;
            bit su;
            nc  = mc[i];
            lvx = (i == 0) ? l0 : l1;
            so  = 0;
            su  = 0;
            if (ld)
                nc = (lvx > mx[i]) ? mx[i] : lvx;
            else if (z0 && !z1) begin
                if (mc[i] < mx[i]) nc = mc[i] + 1;
                else so = 1;
            end else if (z1 && !z0) begin
                if (mc[i] > 0) nc = mc[i] - 1;
                else su = 1;
            end
            mo[i] = so ? 1 : (clr ? 0 : mo[i]);
            mu[i] = su ? 1 : (clr ? 0 : mu[i]);
            mc[i] = nc;
            if (nc > mp[i]) mp[i] = nc;
        end
    endtask

    task automatic check_all();
        check("c0",     c0,  mc[0]);
        check("pico0",  p0,  mp[0]);
        check("lleno0", ll0, 32'(mc[0] == mx[0]));
        check("vacio0", va0, 32'(mc[0] == 0));
        check("casi0",  ca0, 32'(mc[0] >= af[0]));
        check("ovf0",   ov0, mo[0]);
        check("unf0",   un0, mu[0]);
        check("c1",     c1,  mc[1]);
        check("pico1",  p1,  mp[1]);
        check("lleno1", ll1, 32'(mc[1] == mx[1]));
        check("vacio1", va1, 32'(mc[1] == 0));
        check("casi1",  ca1, 32'(mc[1] >= af[1]));
        check("ovf1",   ov1, mo[1]);
        check("unf1",   un1, mu[1]);
    endtask

    task automatic cyc(input bit z0, input bit z1, input bit ld,
                       input int l0, input int l1, input bit clr);
        logic [31:0] a;
        logic [31:0] b;
        a = l0;
        b = l1;
        Z0 = z0; Z1 = z1; load = ld; clr_err = clr;
        lv = a[2:0];
        lv4 = b[3:0];
        @(posedge clk);
        model_step(z0, z1, ld, l0, l1, clr);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        Z0 = 0; Z1 = 0; load = 0; clr_err = 0;
        lv = '0; lv4 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // count up into saturation
        repeat (9) cyc(1, 0, 0, 0, 0, 0);
        check("up_c",    c0,  7);
        check("up_ovf",  ov0, 1);
        check("up_pico", p0,  7);

        // async reset mid-count at c=5
        async_reset();
        repeat (5) cyc(1, 0, 0, 0, 0, 0);
        check("pre_rst_c", c0, 5);
        async_reset();
        check("rst_c",    c0,  0);
        check("rst_vacio", va0, 1);
        check("rst_pico", p0,  0);

        // count down into underflow, then clear
        cyc(0, 0, 1, 2, 2, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 0);
        check("dn_c",   c0,  0);
        check("dn_unf", un0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        check("clr_unf", un0, 0);

        // simultaneous requests at empty and full
        cyc(1, 1, 0, 0, 0, 0);
        check("both0_c",   c0,  0);
        check("both0_unf", un0, 0);
        cyc(0, 0, 1, 7, 10, 0);
        cyc(1, 1, 0, 0, 0, 0);
        check("both7_c",   c0,  7);
        check("both7_ovf", ov0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        check("setwins_ovf", ov0, 1);

        // load overrides and clamps
        cyc(1, 0, 1, 3, 15, 0);
        check("ld3_c",     c0,  3);
        check("ld15_c1",   c1,  10);
        check("ld15_full", ll1, 1);
        cyc(0, 0, 1, 7, 0, 0);
        check("ld7_c",    c0, 7);
        check("ld7_pico", p0, 7);

        // peak holds while draining
        async_reset();
        repeat (5) cyc(1, 0, 0, 0, 0, 0);
        repeat (4) cyc(0, 1, 0, 0, 0, 0);
        check("pk_c",    c0, 1);
        check("pk_pico", p0, 5);
        async_reset();
        check("pk_rst", p0, 0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) == 0)
                async_reset();
            cyc($urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 7) == 0,
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 15)),
                $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_updown_param.md
Name: contador_updown_param

Overview:
Parametrised saturating up/down occupancy counter. Successor to the fixed 3-bit Z1/Z0-mode counter. Adds configurable width and ceiling, synchronous load, empty and almost-full flags, sticky overflow/underflow error flags, and a peak-occupancy register. Drives occupancy displays and admission logic in the top-level control path.

Parameters:
WIDTH, 3, counter width in bits (WIDTH >= 2)
MAX, 7, saturation ceiling; 1 <= MAX <= 2^WIDTH-1
AF_THRESH, 6, almost-full threshold; casi_lleno asserted when c >= AF_THRESH; 0 < AF_THRESH <= MAX

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
Z0  input  1  increment request
Z1  input  1  decrement request
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
clr_err  input  1  synchronous clear of sticky error flags
c  output  WIDTH  current count (registered)
lleno  output  1  c == MAX
vacio  output  1  c == 0
casi_lleno  output  1  c >= AF_THRESH
overflow_err  output  1  sticky: increment requested while full
underflow_err  output  1  sticky: decrement requested while empty
pico  output  WIDTH  highest value c has held since reset (registered)

Behaviour:
- One clock; reset is asynchronous and active-high. The ports are clk and rst.
- While rst=1, independent of clk: c=0, pico=0, overflow_err=0, underflow_err=0. Derived flags: vacio=1, lleno=0, casi_lleno=0.
- Releasing rst mid-operation resumes counting from 0 on the next rising edge. No prior state is kept.
- lleno, vacio and casi_lleno are combinational decodes of the registered c. They have no extra latency and are valid in the same cycle as c.
- Next-count priority, evaluated at each rising edge:
  1. load=1: c <= min(load_val, MAX). Z0/Z1 are ignored that cycle and raise no error.
  2. Z1Z0=00: hold.
  3. Z1Z0=01: if c<MAX then c<=c+1, else hold at MAX and set overflow_err.
  4. Z1Z0=10: if c>0 then c<=c-1, else hold at 0 and set underflow_err.
  5. Z1Z0=11: simultaneous entry and exit. Net zero, hold, no error flagged, even when full or empty.
- Latency: c reflects a request one cycle after the edge that samples it.
- The count never wraps. Arithmetic is WIDTH bits. The comparison against MAX uses WIDTH-bit unsigned compare.
- Sticky errors:
  - Once set, an error flag holds until clr_err=1.
  - If clr_err=1 in the same cycle a new error condition occurs, set wins and the flag stays 1.
  - clr_err does not affect c or pico.
- pico: at each edge, pico <= max(pico, c_next), so pico tracks the new value in the same cycle as c. Load can raise pico. pico never decreases except on rst.
- MAX = 2^WIDTH-1 must behave identically to the fixed 3-bit block: lleno = all ones, and saturation replaces wrap.

Test Plan:
- Reset: assert rst mid-count with c=5 and no clk edge -> c=0, vacio=1, pico=0, errors=0 immediately.
- Count up: from reset, Z1Z0=01 for 9 cycles -> c goes 1..7 then holds 7. casi_lleno=1 from c=6. lleno=1 at c=7. overflow_err=1 after the 8th request, stays 1. pico=7.
- Count down: from c=2, Z1Z0=10 for 3 cycles -> c=1,0,0. vacio=1. underflow_err=1 on the 3rd cycle. Then clr_err=1 with Z1Z0=00 -> underflow_err=0 next cycle.
- Simultaneous inc/dec: at c=7 and at c=0, Z1Z0=11 -> c unchanged, no error set. Then clr_err=1 together with Z1Z0=01 at c=7 -> overflow_err remains 1 (set wins).
- Load: load=1, load_val=3, Z1Z0=01 -> c=3, no increment. load_val=7 -> c=7, pico=7. With WIDTH=4, MAX=10, load_val=15 -> c=10, lleno=1.
- pico hold: count to 5, then decrement to 1 -> pico stays 5. rst -> pico=0.
